// File: rtl/dstack_pkg.sv
// dstack_pkg: shared constants for the data stack.
//   - error codes reported on data_stack.err_code
//   - width of the pop/push count fields and the largest legal count
package dstack_pkg;

    localparam logic [1:0] DSTACK_ERR_NONE    = 2'd0;
    localparam logic [1:0] DSTACK_ERR_UNDER   = 2'd1;
    localparam logic [1:0] DSTACK_ERR_OVER    = 2'd2;
    localparam logic [1:0] DSTACK_ERR_ILLEGAL = 2'd3;

    localparam int DSTACK_CNT_W   = 2;
    localparam int DSTACK_CNT_MAX = 2;

endpackage

// File: rtl/dstack_spill_ram.sv
// dstack_spill_ram: (DEPTH-2) x W register array holding the stack entries
// below tos/nos. Entry i holds the stack word at position i counted from the
// bottom. Contents are not reset.
//
// Ports:
//   clk       in   clock
//   we_hi     in   write wdata_hi at waddr
//   we_lo     in   write wdata_lo at waddr-1
//   waddr     in   write address of the upper word
//   wdata_hi  in   upper write word
//   wdata_lo  in   lower write word
//   raddr0    in   async read address 0 (depth-3 in the parent)
//   raddr1    in   async read address 1 (depth-4 in the parent)
//   rdata0    out  read data 0, 0 when raddr0 is out of range
//   rdata1    out  read data 1, 0 when raddr1 is out of range
//
// The single write port can store one or two adjacent words in a cycle,
// which a pop-0/push-2 command needs to spill both tos and nos.
module dstack_spill_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          we_hi,
    input  logic          we_lo,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata_hi,
    input  logic [W-1:0]  wdata_lo,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    output logic [W-1:0]  rdata0,
    output logic [W-1:0]  rdata1
);

    localparam int N  = DEPTH - 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] N_A = AW'(N);

    logic [W-1:0]  mem_q [N];
    logic [AW-1:0] waddr_lo;

    assign waddr_lo = waddr - AW'(1);

    always_ff @(posedge clk) begin
        if (we_hi && (waddr < N_A)) begin
            mem_q[waddr[IW-1:0]] <= wdata_hi;
        end
        if (we_lo && (waddr_lo < N_A)) begin
            mem_q[waddr_lo[IW-1:0]] <= wdata_lo;
        end
    end

    // Addresses below zero wrap to large values and fall out of range here.
    assign rdata0 = (raddr0 < N_A) ? mem_q[raddr0[IW-1:0]] : '0;
    assign rdata1 = (raddr1 < N_A) ? mem_q[raddr1[IW-1:0]] : '0;

endmodule

// File: rtl/data_stack.sv
// data_stack: operand stack feeding the ALU. tos/nos are dedicated registers,
// deeper entries live in dstack_spill_ram. One command (pop 0..2, then
// push 0..2) per cycle; illegal counts, underflow and overflow set a sticky
// error that blocks commands until err_clr.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid             command strobe
//   cmd_pop, cmd_push     entries removed / added
//   push0, push1          new TOS / new NOS (push 2)
//   err_clr               clears err/err_code, drops the same-cycle command
//   tos, nos              top two entries, 0 when not present
//   depth                 entry count
//   err, err_code         sticky error flag and cause
//   max_depth             high-water mark (only with DSTACK_STATS_EN)
//
// Build option: define DSTACK_STATS_EN to add max_depth.
module data_stack
    import dstack_pkg::*;
#(
    parameter  int W     = 16,
    parameter  int DEPTH = 16,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    input  logic [DSTACK_CNT_W-1:0] cmd_pop,
    input  logic [DSTACK_CNT_W-1:0] cmd_push,
    input  logic [W-1:0]            push0,
    input  logic [W-1:0]            push1,
    input  logic                    err_clr,
    output logic [W-1:0]            tos,
    output logic [W-1:0]            nos,
    output logic [DW-1:0]           depth,
    output logic                    err,
    output logic [1:0]              err_code
`ifdef DSTACK_STATS_EN
    ,
    output logic [DW-1:0]           max_depth
`endif
);

    localparam int SW = DW + 1;
    localparam logic [DSTACK_CNT_W-1:0] CNT_MAX = DSTACK_CNT_W'(DSTACK_CNT_MAX);

    logic [W-1:0]  tos_q, tos_d, nos_q, nos_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;

    logic [W-1:0]  spill0, spill1, r_top, r_next;
    logic [DW-1:0] raddr0, raddr1, waddr;
    logic          we_hi, we_lo;
    logic [SW-1:0] new_depth;
    logic [1:0]    chk_code;

    // spill0 is the entry just below nos, spill1 the one below that.
    assign raddr0 = depth_q - DW'(3);
    assign raddr1 = depth_q - DW'(4);
    assign waddr  = depth_q - DW'(1);

    dstack_spill_ram #(.W(W), .DEPTH(DEPTH), .AW(DW)) u_spill (
        .clk      (clk),
        .we_hi    (we_hi),
        .we_lo    (we_lo),
        .waddr    (waddr),
        .wdata_hi (tos_q),
        .wdata_lo (nos_q),
        .raddr0   (raddr0),
        .raddr1   (raddr1),
        .rdata0   (spill0),
        .rdata1   (spill1)
    );

    // Only evaluated for overflow once pop <= depth, so it never goes negative.
    assign new_depth = SW'(depth_q) - SW'(cmd_pop) + SW'(cmd_push);

    always_comb begin
        chk_code = DSTACK_ERR_NONE;
        if ((cmd_pop > CNT_MAX) || (cmd_push > CNT_MAX)) begin
            chk_code = DSTACK_ERR_ILLEGAL;
        end else if (SW'(cmd_pop) > SW'(depth_q)) begin
            chk_code = DSTACK_ERR_UNDER;
        end else if (new_depth > SW'(DEPTH)) begin
            chk_code = DSTACK_ERR_OVER;
        end
    end

    always_comb begin
        tos_d      = tos_q;
        nos_d      = nos_q;
        depth_d    = depth_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        we_hi      = 1'b0;
        we_lo      = 1'b0;

        // Top two entries left after the pop.
        case (cmd_pop)
            2'd0:    begin r_top = tos_q;  r_next = nos_q;  end
            2'd1:    begin r_top = nos_q;  r_next = spill0; end
            default: begin r_top = spill0; r_next = spill1; end
        endcase

        if (err_clr) begin
            err_d      = 1'b0;
            err_code_d = DSTACK_ERR_NONE;
        end else if (cmd_valid && !err_q) begin
            if (chk_code != DSTACK_ERR_NONE) begin
                err_d      = 1'b1;
                err_code_d = chk_code;
            end else begin
                depth_d = new_depth[DW-1:0];
                case (cmd_push)
                    2'd0:    begin tos_d = r_top; nos_d = r_next; end
                    2'd1:    begin tos_d = push0; nos_d = r_top;  end
                    default: begin tos_d = push0; nos_d = push1;  end
                endcase
                // Net growth pushes the old nos (and for pop0/push2 also the
                // old tos) down into the array; otherwise the surviving
                // entries are already in place.
                we_lo = (cmd_push > cmd_pop) && (depth_q >= DW'(2));
                we_hi = (cmd_pop == 2'd0) && (cmd_push == 2'd2) && (depth_q >= DW'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            depth_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= DSTACK_ERR_NONE;
        end else begin
            depth_q    <= depth_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Data registers need no reset: outputs are masked by depth.
    always_ff @(posedge clk) begin
        tos_q <= tos_d;
        nos_q <= nos_d;
    end

    assign tos      = (depth_q >= DW'(1)) ? tos_q : '0;
    assign nos      = (depth_q >= DW'(2)) ? nos_q : '0;
    assign depth    = depth_q;
    assign err      = err_q;
    assign err_code = err_code_q;

`ifdef DSTACK_STATS_EN
    logic [DW-1:0] max_depth_q, max_depth_d;

    assign max_depth_d = (depth_d > max_depth_q) ? depth_d : max_depth_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_depth_q <= '0;
        end else begin
            max_depth_q <= max_depth_d;
        end
    end

    assign max_depth = max_depth_q;
`endif

endmodule

// File: tb/tb_data_stack.sv
// tb_data_stack: directed scenarios plus randomized commands checked against a
// queue-based reference stack. Define DSTACK_STATS_EN to include the
// max_depth port and its scenario.
module tb_data_stack;

    localparam int W     = 16;
    localparam int DEPTH = 16;
    localparam int DW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_pop = '0;
    logic [1:0]    cmd_push = '0;
    logic [W-1:0]  push0 = '0;
    logic [W-1:0]  push1 = '0;
    logic          err_clr = 1'b0;
    logic [W-1:0]  tos, nos;
    logic [DW-1:0] depth;
    logic          err;
    logic [1:0]    err_code;
`ifdef DSTACK_STATS_EN
    logic [DW-1:0] max_depth;
`endif

    always #5 clk = ~clk;

    data_stack #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_pop   (cmd_pop),
        .cmd_push  (cmd_push),
        .push0     (push0),
        .push1     (push1),
        .err_clr   (err_clr),
        .tos       (tos),
        .nos       (nos),
        .depth     (depth),
        .err       (err),
        .err_code  (err_code)
`ifdef DSTACK_STATS_EN
        ,
        .max_depth (max_depth)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference stack: queue with the top at the back.
    logic [W-1:0] mq[$];
    bit           m_err;
    logic [1:0]   m_code;
    int           m_max;

    function automatic logic [W-1:0] m_tos();
        return (mq.size() >= 1) ? mq[mq.size()-1] : '0;
    endfunction

    function automatic logic [W-1:0] m_nos();
        return (mq.size() >= 2) ? mq[mq.size()-2] : '0;
    endfunction

    // Applies one cycle of stimulus and advances the reference model.
    task automatic drive(input bit v, input int p, input int u,
                         input logic [W-1:0] w0, input logic [W-1:0] w1, input bit clr);
        @(negedge clk);
        cmd_valid = v;
        cmd_pop   = 2'(p);
        cmd_push  = 2'(u);
        push0     = w0;
        push1     = w1;
        err_clr   = clr;
        if (clr) begin
            m_err  = 1'b0;
            m_code = 2'd0;
        end else if (v && !m_err) begin
            if (p > 2 || u > 2) begin
                m_err = 1'b1; m_code = 2'd3;
            end else if (p > mq.size()) begin
                m_err = 1'b1; m_code = 2'd1;
            end else if (mq.size() - p + u > DEPTH) begin
                m_err = 1'b1; m_code = 2'd2;
            end else begin
                repeat (p) void'(mq.pop_back());
                if (u == 2) mq.push_back(w1);
                if (u >= 1) mq.push_back(w0);
                if (mq.size() > m_max) m_max = mq.size();
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
    endtask

    // Reset with a push command presented in the same cycle.
    task automatic reset_dut();
        @(negedge clk);
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_pop   = 2'd0;
        cmd_push  = 2'd1;
        push0     = 16'hDEAD;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        mq.delete();
        m_err  = 1'b0;
        m_code = 2'd0;
        m_max  = 0;
    endtask

    task automatic test_reset();
        reset_dut();
        drive(1, 0, 2, 16'hAAAA, 16'hBBBB, 0);
        drive(1, 3, 0, 16'h0, 16'h0, 0);
        reset_dut();
        n_checks++;
        if ({tos, nos, depth, err, err_code} !== {16'h0, 16'h0, DW'(0), 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL reset: tos=%h nos=%h depth=%0d err=%0d code=%0d, expected all 0",
                     tos, nos, depth, err, err_code);
        end
`ifdef DSTACK_STATS_EN
        n_checks++;
        if (max_depth !== DW'(0)) begin
            n_errors++;
            $display("FAIL reset_max: max_depth=%0d expected 0", max_depth);
        end
`endif
    endtask

    task automatic test_push_add();
        reset_dut();
        drive(1, 0, 1, 16'h1234, 16'h0, 0);
        drive(1, 0, 1, 16'h5678, 16'h0, 0);
        n_checks++;
        if ({tos, nos, depth} !== {16'h5678, 16'h1234, DW'(2)}) begin
            n_errors++;
            $display("FAIL push2: tos=%h nos=%h depth=%0d, expected 5678 1234 2", tos, nos, depth);
        end
        drive(1, 2, 1, 16'h68AC, 16'h0, 0);
        n_checks++;
        if ({tos, nos, depth} !== {16'h68AC, 16'h0, DW'(1)}) begin
            n_errors++;
            $display("FAIL add: tos=%h nos=%h depth=%0d, expected 68ac 0 1", tos, nos, depth);
        end
    endtask

    task automatic test_swap_spill();
        reset_dut();
        for (int i = 1; i <= 3; i++) drive(1, 0, 1, W'(i), 16'h0, 0);
        n_checks++;
        if ({tos, nos, depth} !== {16'h3, 16'h2, DW'(3)}) begin
            n_errors++;
            $display("FAIL push3: tos=%h nos=%h depth=%0d, expected 3 2 3", tos, nos, depth);
        end
        drive(1, 2, 2, 16'h0002, 16'h0003, 0);
        n_checks++;
        if ({tos, nos, depth} !== {16'h2, 16'h3, DW'(3)}) begin
            n_errors++;
            $display("FAIL swap: tos=%h nos=%h depth=%0d, expected 2 3 3", tos, nos, depth);
        end
        drive(1, 1, 0, 16'h0, 16'h0, 0);
        n_checks++;
        if ({tos, nos, depth} !== {16'h3, 16'h1, DW'(2)}) begin
            n_errors++;
            $display("FAIL pop_refill: tos=%h nos=%h depth=%0d, expected 3 1 2", tos, nos, depth);
        end
        drive(1, 1, 0, 16'h0, 16'h0, 0);
        n_checks++;
        if ({tos, nos, depth} !== {16'h1, 16'h0, DW'(1)}) begin
            n_errors++;
            $display("FAIL pop_last: tos=%h nos=%h depth=%0d, expected 1 0 1", tos, nos, depth);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] vals [DEPTH];
        reset_dut();
        for (int i = 0; i < DEPTH; i++) begin
            vals[i] = W'($urandom);
            drive(1, 0, 1, vals[i], 16'h0, 0);
        end
        drive(1, 0, 1, 16'hBEEF, 16'h0, 0);
        n_checks++;
        if ({err, err_code, depth, tos} !== {1'b1, 2'd2, DW'(DEPTH), vals[DEPTH-1]}) begin
            n_errors++;
            $display("FAIL overflow: err=%0d code=%0d depth=%0d tos=%h, expected 1 2 %0d %h",
                     err, err_code, depth, tos, DEPTH, vals[DEPTH-1]);
        end
        drive(1, 1, 1, 16'h1111, 16'h0, 0);
        n_checks++;
        if ({err, err_code, depth, tos} !== {1'b1, 2'd2, DW'(DEPTH), vals[DEPTH-1]}) begin
            n_errors++;
            $display("FAIL drop_in_err: err=%0d code=%0d depth=%0d tos=%h, expected 1 2 %0d %h",
                     err, err_code, depth, tos, DEPTH, vals[DEPTH-1]);
        end
        drive(0, 0, 0, 16'h0, 16'h0, 1);
        n_checks++;
        if ({err, err_code} !== {1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL err_clr: err=%0d code=%0d, expected 0 0", err, err_code);
        end
        // Unwind the full stack, exercising every spill cell.
        for (int i = DEPTH - 1; i >= 1; i--) begin
            drive(1, 1, 0, 16'h0, 16'h0, 0);
            n_checks++;
            if ({tos, depth} !== {vals[i-1], DW'(i)}) begin
                n_errors++;
                $display("FAIL unwind_%0d: tos=%h depth=%0d, expected %h %0d",
                         i, tos, depth, vals[i-1], i);
            end
        end
    endtask

    task automatic test_under_illegal();
        reset_dut();
        drive(1, 0, 1, 16'h00AA, 16'h0, 0);
        drive(1, 2, 0, 16'h0, 16'h0, 0);
        n_checks++;
        if ({err, err_code, depth, tos} !== {1'b1, 2'd1, DW'(1), 16'h00AA}) begin
            n_errors++;
            $display("FAIL underflow: err=%0d code=%0d depth=%0d tos=%h, expected 1 1 1 00aa",
                     err, err_code, depth, tos);
        end
        drive(0, 0, 0, 16'h0, 16'h0, 1);
        drive(1, 3, 0, 16'h0, 16'h0, 0);
        n_checks++;
        if ({err, err_code, depth} !== {1'b1, 2'd3, DW'(1)}) begin
            n_errors++;
            $display("FAIL illegal_pop3: err=%0d code=%0d depth=%0d, expected 1 3 1", err, err_code, depth);
        end
        drive(1, 0, 1, 16'h2222, 16'h0, 1);
        n_checks++;
        if ({err, err_code, depth, tos} !== {1'b0, 2'd0, DW'(1), 16'h00AA}) begin
            n_errors++;
            $display("FAIL clr_drops_cmd: err=%0d code=%0d depth=%0d tos=%h, expected 0 0 1 00aa",
                     err, err_code, depth, tos);
        end
        drive(1, 0, 3, 16'h3333, 16'h0, 0);
        n_checks++;
        if ({err, err_code, depth} !== {1'b1, 2'd3, DW'(1)}) begin
            n_errors++;
            $display("FAIL illegal_push3: err=%0d code=%0d depth=%0d, expected 1 3 1", err, err_code, depth);
        end
    endtask

    task automatic test_random();
        int p, u;
        bit v, clr;
        reset_dut();
        for (int n = 0; n < 600; n++) begin
            v   = ($urandom_range(0, 9) != 0);
            clr = m_err ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 39) == 0);
            p   = ($urandom_range(0, 24) == 0) ? 3 : ((n < 150) ? $urandom_range(0, 1) : $urandom_range(0, 2));
            u   = ($urandom_range(0, 24) == 0) ? 3 : $urandom_range(0, 2);
            drive(v, p, u, W'($urandom), W'($urandom), clr);
            n_checks++;
            if ({tos, nos, depth, err, err_code} !== {m_tos(), m_nos(), DW'(mq.size()), m_err, m_code}) begin
                n_errors++;
                $display("FAIL random_%0d: tos=%h nos=%h depth=%0d err=%0d code=%0d, expected %h %h %0d %0d %0d",
                         n, tos, nos, depth, err, err_code, m_tos(), m_nos(), mq.size(), m_err, m_code);
            end
`ifdef DSTACK_STATS_EN
            n_checks++;
            if (max_depth !== DW'(m_max)) begin
                n_errors++;
                $display("FAIL random_max_%0d: max_depth=%0d expected %0d", n, max_depth, m_max);
            end
`endif
        end
    endtask

`ifdef DSTACK_STATS_EN
    task automatic test_stats();
        reset_dut();
        for (int i = 0; i < 5; i++) drive(1, 0, 1, W'(i + 10), 16'h0, 0);
        drive(1, 2, 0, 16'h0, 16'h0, 0);
        drive(1, 1, 0, 16'h0, 16'h0, 0);
        drive(1, 0, 1, 16'h0077, 16'h0, 0);
        n_checks++;
        if ({depth, max_depth} !== {DW'(3), DW'(5)}) begin
            n_errors++;
            $display("FAIL stats: depth=%0d max_depth=%0d, expected 3 5", depth, max_depth);
        end
        drive(0, 0, 0, 16'h0, 16'h0, 1);
        n_checks++;
        if (max_depth !== DW'(5)) begin
            n_errors++;
            $display("FAIL stats_clr: max_depth=%0d expected 5", max_depth);
        end
        reset_dut();
        n_checks++;
        if (max_depth !== DW'(0)) begin
            n_errors++;
            $display("FAIL stats_reset: max_depth=%0d expected 0", max_depth);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_push_add();
        test_swap_spill();
        test_overflow();
        test_under_illegal();
`ifdef DSTACK_STATS_EN
        test_stats();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
